rush_tracker: RTL and testbench

Parametrised successor to the single-shot rush-hour recorder in the parking lot meter. It counts occupancy over N_SPOTS presence sensors and detects rush periods with hysteresis: a period opens at a fill threshold and closes at a drain threshold. It logs up to MAX_EVENTS start/end hour pairs per day and exposes them through an indexed, registered read port for the display/report logic. It sits beside the lot clock and spot sensors, and can be restarted each day with new_day without a global reset.

---
 rtl/rush_tracker.sv | 206 ++++++++++++++++++++
 tb/tb_rush_tracker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rush_tracker.sv
// rush_tracker
//   Counts occupancy over N_SPOTS presence sensors and detects rush periods
//   with hysteresis. A period opens when occupancy reaches FULL_THRESH and
//   closes when it falls to EMPTY_THRESH. Up to MAX_EVENTS start/end hour
//   pairs are logged per day and read back through a registered, indexed port.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   hour       current lot hour
//   spots      spot presence, bit i = car in spot i
//   new_day    one-cycle pulse: clear log, restart tracking
//   rd_idx     log entry to read
//   rd_start   start hour of entry rd_idx (1-cycle latency)
//   rd_end     end hour of entry rd_idx (1-cycle latency)
//   rd_valid   entry rd_idx holds a recorded rush (1-cycle latency)
//   num_events rush periods opened today, saturating at MAX_EVENTS
//   in_rush    rush period currently open
//   occupancy  registered popcount of spots
//   day_done   day closed, no further recording until new_day
//   overflow   sticky: a rush opened after the log was full
module rush_tracker #(
    parameter int unsigned N_SPOTS      = 3,
    parameter int unsigned HOUR_W       = 4,
    parameter int unsigned DAY_END      = 8,
    parameter int unsigned FULL_THRESH  = N_SPOTS,
    parameter int unsigned EMPTY_THRESH = 0,
    parameter int unsigned MAX_EVENTS   = 4,
    localparam int unsigned CNT_W = $clog2(N_SPOTS + 1),
    localparam int unsigned IDX_W = (MAX_EVENTS > 1) ? $clog2(MAX_EVENTS) : 1,
    localparam int unsigned EV_W  = $clog2(MAX_EVENTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HOUR_W-1:0] hour,
    input  logic [N_SPOTS-1:0] spots,
    input  logic              new_day,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [HOUR_W-1:0] rd_start,
    output logic [HOUR_W-1:0] rd_end,
    output logic              rd_valid,
    output logic [EV_W-1:0]   num_events,
    output logic              in_rush,
    output logic [CNT_W-1:0]  occupancy,
    output logic              day_done,
    output logic              overflow
);

    localparam logic [HOUR_W-1:0] L_NO_RUSH = '1;
    localparam logic [HOUR_W-1:0] L_DAY_END = HOUR_W'(DAY_END);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUSH,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   w_occ_now;
    logic               w_day_end;
    logic               w_full;
    logic               w_empty;
    logic               w_open;
    logic               w_close;
    logic [HOUR_W-1:0]  w_close_hour;

    logic [HOUR_W-1:0]  r_start [MAX_EVENTS];
    logic [HOUR_W-1:0]  r_end   [MAX_EVENTS];
    logic               r_valid [MAX_EVENTS];
    logic [EV_W-1:0]    r_num;
    logic [IDX_W-1:0]   r_open_idx;
    logic               r_open_rec;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_occ;

    logic [HOUR_W-1:0]  r_rd_start;
    logic [HOUR_W-1:0]  r_rd_end;
    logic               r_rd_valid;

    always_comb begin
        w_occ_now = '0;
        for (int unsigned i = 0; i < N_SPOTS; i++) begin
            w_occ_now = w_occ_now + CNT_W'(spots[i]);
        end
    end

    assign w_day_end = (hour == L_DAY_END);
    assign w_full    = (32'(w_occ_now) >= FULL_THRESH);
    assign w_empty   = (32'(w_occ_now) <= EMPTY_THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_occ   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_now;
        end
    end

    // new_day outranks everything; day end outranks threshold events.
    always_comb begin
        w_state_nxt  = r_state;
        w_open       = 1'b0;
        w_close      = 1'b0;
        w_close_hour = hour;
        if (new_day) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_day_end) begin
                        w_state_nxt = S_DONE;
                    end else if (w_full) begin
                        w_state_nxt = S_RUSH;
                        w_open      = 1'b1;
                    end
                end
                S_RUSH: begin
                    if (w_day_end) begin
                        w_state_nxt  = S_DONE;
                        w_close      = 1'b1;
                        w_close_hour = L_DAY_END;
                    end else if (w_empty) begin
                        w_state_nxt = S_IDLE;
                        w_close     = 1'b1;
                    end
                end
                S_DONE: w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // r_open_rec remembers whether the open rush got a log slot, so a rush
    // opened while the log is full closes without touching any entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_EVENTS; i++) begin
                r_start[i] <= L_NO_RUSH;
                r_end[i]   <= L_NO_RUSH;
                r_valid[i] <= 1'b0;
            end
            r_num      <= '0;
            r_open_idx <= '0;
            r_open_rec <= 1'b0;
            r_overflow <= 1'b0;
        end else if (new_day) begin
            for (int unsigned i = 0; i < MAX_EVENTS; i++) begin
                r_start[i] <= L_NO_RUSH;
                r_end[i]   <= L_NO_RUSH;
                r_valid[i] <= 1'b0;
            end
            r_num      <= '0;
            r_open_idx <= '0;
            r_open_rec <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_open) begin
                if (32'(r_num) < MAX_EVENTS) begin
                    r_start[r_num[IDX_W-1:0]] <= hour;
                    r_end[r_num[IDX_W-1:0]]   <= L_NO_RUSH;
                    r_valid[r_num[IDX_W-1:0]] <= 1'b1;
                    r_open_idx                <= r_num[IDX_W-1:0];
                    r_open_rec                <= 1'b1;
                    r_num                     <= r_num + EV_W'(1);
                end else begin
                    r_overflow <= 1'b1;
                    r_open_rec <= 1'b0;
                end
            end
            if (w_close && r_open_rec) begin
                r_end[r_open_idx] <= w_close_hour;
            end
        end
    end

    // Read port samples the array before this cycle's write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_start <= L_NO_RUSH;
            r_rd_end   <= L_NO_RUSH;
            r_rd_valid <= 1'b0;
        end else if (32'(rd_idx) < MAX_EVENTS) begin
            r_rd_start <= r_start[rd_idx];
            r_rd_end   <= r_end[rd_idx];
            r_rd_valid <= r_valid[rd_idx];
        end else begin
            r_rd_start <= L_NO_RUSH;
            r_rd_end   <= L_NO_RUSH;
            r_rd_valid <= 1'b0;
        end
    end

    assign rd_start   = r_rd_start;
    assign rd_end     = r_rd_end;
    assign rd_valid   = r_rd_valid;
    assign num_events = r_num;
    assign in_rush    = (r_state == S_RUSH);
    assign day_done   = (r_state == S_DONE);
    assign occupancy  = r_occ;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_rush_tracker.sv
// tb_rush_tracker
//   Self-checking bench for rush_tracker. Instance A uses default parameters;
//   instance B uses N_SPOTS=6, FULL_THRESH=5, EMPTY_THRESH=1, MAX_EVENTS=2
//   for the hysteresis and log-overflow scenarios. Read-port expectations are
//   queued when a read index is driven and compared when the registered
//   result appears.
module tb_rush_tracker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A (defaults)
    logic [3:0] a_hour = '0;
    logic [2:0] a_spots = '0;
    logic       a_new_day = 1'b0;
    logic [1:0] a_rd_idx = '0;
    logic [3:0] a_rd_start, a_rd_end;
    logic       a_rd_valid;
    logic [2:0] a_num;
    logic       a_in_rush, a_day_done, a_overflow;
    logic [1:0] a_occ;

    // Instance B (hysteresis / small log)
    logic [3:0] b_hour = '0;
    logic [5:0] b_spots = '0;
    logic       b_new_day = 1'b0;
    logic [0:0] b_rd_idx = '0;
    logic [3:0] b_rd_start, b_rd_end;
    logic       b_rd_valid;
    logic [1:0] b_num;
    logic       b_in_rush, b_day_done, b_overflow;
    logic [2:0] b_occ;

    rush_tracker u_dut_a (
        .clk(clk), .rst(rst), .hour(a_hour), .spots(a_spots), .new_day(a_new_day),
        .rd_idx(a_rd_idx), .rd_start(a_rd_start), .rd_end(a_rd_end), .rd_valid(a_rd_valid),
        .num_events(a_num), .in_rush(a_in_rush), .occupancy(a_occ),
        .day_done(a_day_done), .overflow(a_overflow)
    );

    rush_tracker #(
        .N_SPOTS(6), .FULL_THRESH(5), .EMPTY_THRESH(1), .MAX_EVENTS(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .hour(b_hour), .spots(b_spots), .new_day(b_new_day),
        .rd_idx(b_rd_idx), .rd_start(b_rd_start), .rd_end(b_rd_end), .rd_valid(b_rd_valid),
        .num_events(b_num), .in_rush(b_in_rush), .occupancy(b_occ),
        .day_done(b_day_done), .overflow(b_overflow)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic        is_b;
        logic [1:0]  idx;
        logic [3:0]  s;
        logic [3:0]  e;
        logic        v;
        int unsigned due;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    rd_exp_t m_x;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            m_x = sb_q.pop_front();
            if (m_x.is_b) begin
                check($sformatf("b_rd_start[%0d]", m_x.idx), b_rd_start, m_x.s);
                check($sformatf("b_rd_end[%0d]", m_x.idx), b_rd_end, m_x.e);
                check($sformatf("b_rd_valid[%0d]", m_x.idx), b_rd_valid, m_x.v);
            end else begin
                check($sformatf("a_rd_start[%0d]", m_x.idx), a_rd_start, m_x.s);
                check($sformatf("a_rd_end[%0d]", m_x.idx), a_rd_end, m_x.e);
                check($sformatf("a_rd_valid[%0d]", m_x.idx), a_rd_valid, m_x.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input logic [3:0] h, input logic [2:0] sp);
        a_hour = h;
        a_spots = sp;
        tick();
    endtask

    task automatic step_b(input logic [3:0] h, input logic [5:0] sp);
        b_hour = h;
        b_spots = sp;
        tick();
    endtask

    task automatic rd_a(input logic [1:0] i, input logic [3:0] es, input logic [3:0] ee, input logic ev);
        a_rd_idx = i;
        sb_q.push_back('{is_b: 1'b0, idx: i, s: es, e: ee, v: ev, due: cyc + 1});
    endtask

    task automatic rd_b(input logic [0:0] i, input logic [3:0] es, input logic [3:0] ee, input logic ev);
        b_rd_idx = i;
        sb_q.push_back('{is_b: 1'b1, idx: {1'b0, i}, s: es, e: ee, v: ev, due: cyc + 1});
    endtask

    task automatic pulse_new_day_a();
        a_new_day = 1'b1;
        tick();
        a_new_day = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset
        #2 rst = 1'b1;
        tick();
        tick();
        check("rst_num", a_num, 0);
        check("rst_in_rush", a_in_rush, 0);
        check("rst_day_done", a_day_done, 0);
        check("rst_overflow", a_overflow, 0);
        check("rst_occ", a_occ, 0);
        check("rst_rd_start", a_rd_start, 15);
        check("rst_rd_end", a_rd_end, 15);
        check("rst_rd_valid", a_rd_valid, 0);
        check("rst_b_num", b_num, 0);
        rst = 1'b0;

        // Single rush 2..4
        step_a(4'd0, 3'b001);
        step_a(4'd1, 3'b001);
        check("t1_occ_lag", a_occ, 1);
        check("t1_idle", a_in_rush, 0);
        step_a(4'd2, 3'b111);
        check("t1_in_rush_open", a_in_rush, 1);
        check("t1_num", a_num, 1);
        check("t1_occ_full", a_occ, 3);
        step_a(4'd3, 3'b001);
        check("t1_in_rush_mid", a_in_rush, 1);
        rd_a(2'd0, 4'd2, 4'd15, 1'b1);   // read collides with the closing write
        step_a(4'd4, 3'b000);
        check("t1_in_rush_close", a_in_rush, 0);
        rd_a(2'd0, 4'd2, 4'd4, 1'b1);
        tick();
        rd_a(2'd1, 4'd15, 4'd15, 1'b0);
        tick();
        tick();

        // Two rushes in one day
        pulse_new_day_a();
        check("t2_num_clr", a_num, 0);
        step_a(4'd0, 3'b000);
        step_a(4'd1, 3'b111);
        step_a(4'd2, 3'b000);
        step_a(4'd3, 3'b000);
        step_a(4'd4, 3'b000);
        step_a(4'd5, 3'b111);
        step_a(4'd6, 3'b000);
        step_a(4'd7, 3'b000);
        check("t2_num", a_num, 2);
        rd_a(2'd0, 4'd1, 4'd2, 1'b1);
        tick();
        rd_a(2'd1, 4'd5, 4'd6, 1'b1);
        tick();
        rd_a(2'd2, 4'd15, 4'd15, 1'b0);
        tick();
        rd_a(2'd3, 4'd15, 4'd15, 1'b0);
        tick();
        tick();

        // Rush runs into day end
        pulse_new_day_a();
        step_a(4'd2, 3'b000);
        step_a(4'd3, 3'b111);
        step_a(4'd4, 3'b011);
        step_a(4'd5, 3'b111);
        step_a(4'd7, 3'b111);
        check("t3_in_rush", a_in_rush, 1);
        step_a(4'd8, 3'b111);
        check("t3_day_done", a_day_done, 1);
        check("t3_in_rush_off", a_in_rush, 0);
        step_a(4'd9, 3'b000);
        step_a(4'd10, 3'b111);
        step_a(4'd11, 3'b000);
        step_a(4'd12, 3'b111);
        check("t3_done_hold", a_day_done, 1);
        check("t3_done_no_rush", a_in_rush, 0);
        check("t3_num_hold", a_num, 1);
        rd_a(2'd0, 4'd3, 4'd8, 1'b1);
        tick();
        rd_a(2'd1, 4'd15, 4'd15, 1'b0);
        tick();
        tick();

        // new_day after DONE
        a_hour = 4'd0;
        a_spots = 3'b000;
        pulse_new_day_a();
        check("t4_day_done_clr", a_day_done, 0);
        check("t4_num_clr", a_num, 0);
        check("t4_overflow_clr", a_overflow, 0);
        check("t4_in_rush", a_in_rush, 0);
        rd_a(2'd0, 4'd15, 4'd15, 1'b0);
        tick();
        tick();
        step_a(4'd2, 3'b111);
        step_a(4'd3, 3'b000);
        check("t4_num_new", a_num, 1);
        rd_a(2'd0, 4'd2, 4'd3, 1'b1);
        tick();
        tick();

        // Hysteresis and overflow on instance B
        step_b(4'd0, 6'b000000);
        step_b(4'd1, 6'b011111);
        check("b_in_rush_open", b_in_rush, 1);
        check("b_occ5", b_occ, 5);
        step_b(4'd2, 6'b000111);
        check("b_hyst_hold", b_in_rush, 1);
        step_b(4'd3, 6'b011111);
        check("b_no_reopen", b_num, 1);
        step_b(4'd4, 6'b000001);
        check("b_close", b_in_rush, 0);
        step_b(4'd5, 6'b000011);
        check("b_hyst_idle", b_in_rush, 0);
        step_b(4'd6, 6'b111111);
        step_b(4'd7, 6'b000000);
        check("b_num2", b_num, 2);
        check("b_no_ovf_yet", b_overflow, 0);
        step_b(4'd9, 6'b011111);
        check("b_overflow", b_overflow, 1);
        check("b_num_sat", b_num, 2);
        check("b_in_rush_ovf", b_in_rush, 1);
        step_b(4'd10, 6'b000111);
        check("b_in_rush_ovf_mid", b_in_rush, 1);
        step_b(4'd11, 6'b000000);
        check("b_in_rush_ovf_close", b_in_rush, 0);
        check("b_overflow_sticky", b_overflow, 1);
        rd_b(1'b0, 4'd1, 4'd4, 1'b1);
        tick();
        rd_b(1'b1, 4'd6, 4'd7, 1'b1);
        tick();
        tick();

        // Async reset mid-rush, asserted between clock edges
        step_a(4'd4, 3'b111);
        check("t5_in_rush_pre", a_in_rush, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_in_rush", a_in_rush, 0);
        check("t5_num", a_num, 0);
        check("t5_occ", a_occ, 0);
        check("t5_rd_valid", a_rd_valid, 0);
        check("t5_rd_start", a_rd_start, 15);
        check("t5_b_overflow", b_overflow, 0);
        check("t5_b_num", b_num, 0);
        tick();
        rst = 1'b0;
        a_spots = 3'b000;
        rd_a(2'd1, 4'd15, 4'd15, 1'b0);
        tick();
        rd_a(2'd0, 4'd15, 4'd15, 1'b0);
        tick();
        tick();

        check("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
